// File: rtl/boot_defs.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding and
// image/word byte-lane constants.
package boot_defs;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } boot_state_e;

  localparam int HDR_BYTES  = 4;
  localparam int CSUM_BYTES = 4;

  // Header, data words and checksum all share one word assembler.
  localparam int BYTES_PER_WORD = (HDR_BYTES > CSUM_BYTES) ? HDR_BYTES : CSUM_BYTES;
  localparam int LANE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * LANE_W;
  localparam int LANE_CNT_W     = $clog2(BYTES_PER_WORD);

  localparam logic [LANE_CNT_W-1:0]     LAST_LANE = LANE_CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [BYTES_PER_WORD-1:0] ALL_LANES = '1;

endpackage

// File: rtl/boot_word_asm.sv
// Little-endian byte-to-word assembler; word_vld pulses for one cycle after the
// last byte of a word is accepted, with word_out holding the assembled word.
module boot_word_asm
  import boot_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_vld,
  input  logic [LANE_W-1:0] byte_in,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_out
);

  logic [LANE_CNT_W-1:0]    lane;
  logic [WORD_W-LANE_W-1:0] part;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      lane     <= '0;
      part     <= '0;
      word_vld <= 1'b0;
      word_out <= '0;
    end else begin
      word_vld <= 1'b0;
      if (byte_vld) begin
        if (lane == LAST_LANE) begin
          word_out <= {byte_in, part};
          word_vld <= 1'b1;
          lane     <= '0;
        end else begin
          part[{lane, 3'b000} +: LANE_W] <= byte_in;
          lane <= lane + LANE_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/im_boot_loader.sv
// Boot loader between the CPU instruction port and instruction SRAM: loads a
// byte-stream image, verifies its checksum, then hands the SRAM to the CPU.
//
//   state | meaning
//   HDR   | collecting the 4-byte word count N
//   DATA  | collecting data words and writing them to SRAM
//   CSUM  | collecting the checksum word
//   DONE  | image verified; CPU owns SRAM and runs
//   ERR   | length or checksum failure; CPU held in reset
module im_boot_loader
  import boot_defs::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic [3:0]        cpu_w_en,
  input  logic [31:0]       cpu_address,
  input  logic [31:0]       cpu_write_data,
  output logic [31:0]       cpu_read_data,
  output logic [3:0]        im_w_en,
  output logic [ADDR_W-1:0] im_address,
  output logic [31:0]       im_write_data,
  input  logic [31:0]       im_read_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  boot_state_e       state, state_nxt;
  logic              word_vld;
  logic [WORD_W-1:0] word_out;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  n_words;
  logic [31:0]       sum;
  logic              pass_now;
  logic              fail_now;
  logic              wr_now;
  logic [ADDR_W-1:0] wr_addr;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^cpu_address[31:ADDR_W];

  boot_word_asm u_word_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (pass_now || fail_now),
    .byte_vld (s_valid && s_ready),
    .byte_in  (s_data),
    .word_vld (word_vld),
    .word_out (word_out)
  );

  assign wr_now  = (state == ST_DATA) && word_vld;
  assign wr_addr = BASE_ADDR + ADDR_W'({idx, 2'b00});

  // Terminal decisions are visible in the same cycle the deciding word arrives,
  // so done/error rise one cycle after the last byte of the header or checksum.
  always_comb begin
    state_nxt = state;
    pass_now  = 1'b0;
    fail_now  = 1'b0;
    case (state)
      ST_HDR: begin
        if (word_vld) begin
          if (word_out > 32'(MAX_WORDS)) begin
            state_nxt = ST_ERR;
            fail_now  = 1'b1;
          end else if (word_out == '0) begin
            state_nxt = ST_CSUM;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_vld && (idx == n_words - IDX_W'(1))) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        if (word_vld) begin
          if (word_out == sum) begin
            state_nxt = ST_DONE;
            pass_now  = 1'b1;
          end else begin
            state_nxt = ST_ERR;
            fail_now  = 1'b1;
          end
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_HDR;
      idx     <= '0;
      n_words <= '0;
      sum     <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_HDR) && word_vld) n_words <= word_out[IDX_W-1:0];
      if (wr_now) begin
        idx <= idx + IDX_W'(1);
        sum <= sum + word_out;
      end
    end
  end

  always_comb begin
    s_ready       = 1'b0;
    im_w_en       = '0;
    im_address    = '0;
    im_write_data = '0;
    cpu_read_data = '0;
    cpu_rst       = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    if (rst) begin
      if ((state == ST_DONE) || pass_now) begin
        im_w_en       = cpu_w_en;
        im_address    = cpu_address[ADDR_W-1:0];
        im_write_data = cpu_write_data;
        cpu_read_data = im_read_data;
        cpu_rst       = 1'b1;
        done          = 1'b1;
      end else if ((state == ST_ERR) || fail_now) begin
        error = 1'b1;
      end else begin
        s_ready = 1'b1;
        if (wr_now) begin
          im_w_en       = ALL_LANES;
          im_address    = wr_addr;
          im_write_data = word_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_im_boot_loader.sv
// Self-checking bench for im_boot_loader: a byte-count based image model
// predicts every output each cycle; literal checks pin the directed cases.
module tb_im_boot_loader;

  localparam int MAXW = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic [3:0]  cpu_w_en = '0;
  logic [31:0] cpu_address = '0;
  logic [31:0] cpu_write_data = '0;
  logic [31:0] cpu_read_data;
  logic [3:0]  im_w_en;
  logic [15:0] im_address;
  logic [31:0] im_write_data;
  logic [31:0] im_read_data = '0;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mb[$];
  bit          acc_last = 1'b0;
  logic [7:0]  img[$];
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  bit          hold_cpu = 1'b0;

  always #5 clk = ~clk;

  im_boot_loader dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .cpu_w_en       (cpu_w_en),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .im_w_en        (im_w_en),
    .im_address     (im_address),
    .im_write_data  (im_write_data),
    .im_read_data   (im_read_data),
    .cpu_rst        (cpu_rst),
    .done           (done),
    .error          (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(input int off);
    return {mb[off+3], mb[off+2], mb[off+1], mb[off]};
  endfunction

  // Everything follows from how many image bytes have been accepted since reset.
  function automatic void model_expect(output bit e_ready, output bit e_done, output bit e_err,
                                       output bit e_wr, output logic [31:0] e_addr,
                                       output logic [31:0] e_data);
    int b;
    int n;
    bit over;
    bit fin;
    logic [31:0] sum;
    logic [31:0] cs;
    b = mb.size();
    n = 0; over = 0; fin = 0; sum = '0; cs = '0;
    e_ready = 0; e_done = 0; e_err = 0; e_wr = 0; e_addr = '0; e_data = '0;
    if (rst) begin
      if (b >= 4) begin
        over = mword(0) > 32'(MAXW);
        if (!over) n = int'(mword(0));
      end
      if (b >= 4 && !over && b >= 8 + 4 * n) begin
        fin = 1;
        for (int i = 0; i < n; i++) sum += mword(4 + 4 * i);
        cs = mword(4 + 4 * n);
      end
      e_done  = fin && (cs == sum);
      e_err   = over || (fin && (cs != sum));
      e_ready = !over && !fin;
      if (acc_last && !over && b >= 8 && (b % 4) == 0 && b <= 4 + 4 * n) begin
        e_wr   = 1;
        e_addr = 32'(b - 8);
        e_data = mword(b - 4);
      end
    end
  endfunction

  always @(posedge clk) begin : model_update
    bit r, d, e, w;
    logic [31:0] a, v;
    model_expect(r, d, e, w, a, v);
    if (!rst) begin
      mb.delete();
      acc_last = 0;
    end else if (r && s_valid) begin
      mb.push_back(s_data);
      acc_last = 1;
    end else begin
      acc_last = 0;
    end
  end

  always @(negedge clk) begin : compare
    bit r, d, e, w;
    logic [31:0] a, v;
    logic [3:0]  x_wen;
    logic [15:0] x_addr;
    logic [31:0] x_wd, x_rd;
    model_expect(r, d, e, w, a, v);
    if (d) begin
      x_wen = cpu_w_en; x_addr = cpu_address[15:0]; x_wd = cpu_write_data; x_rd = im_read_data;
    end else begin
      x_wen  = w ? 4'hF : 4'h0;
      x_addr = w ? a[15:0] : 16'h0;
      x_wd   = w ? v : 32'h0;
      x_rd   = 32'h0;
    end
    check("s_ready", 32'(s_ready), 32'(r));
    check("done", 32'(done), 32'(d));
    check("error", 32'(error), 32'(e));
    check("cpu_rst", 32'(cpu_rst), 32'(d));
    check("im_w_en", 32'(im_w_en), 32'(x_wen));
    check("im_address", 32'(im_address), 32'(x_addr));
    check("im_write_data", im_write_data, x_wd);
    check("cpu_read_data", cpu_read_data, x_rd);
    if (rst && !done && im_w_en != 4'h0) begin
      wlog_addr.push_back(32'(im_address));
      wlog_data.push_back(im_write_data);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!hold_cpu) begin
        cpu_w_en       = 4'($urandom);
        cpu_address    = $urandom;
        cpu_write_data = $urandom;
        im_read_data   = $urandom;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) img.push_back(w[8*k +: 8]);
  endfunction

  function automatic void build_good(input logic [31:0] csum);
    img.delete();
    push_word(32'd2);
    push_word(32'h0000_0013);
    push_word(32'h0010_0093);
    push_word(csum);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int max_gap, output bit ok);
    int gap;
    gap = $urandom_range(max_gap, 0);
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      tick();
    end
    s_valid = 1'b1;
    s_data  = b;
    ok = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic send_bytes(input int count, input int max_gap);
    bit ok;
    for (int i = 0; i < count && i < img.size(); i++) begin
      send_byte(img[i], max_gap, ok);
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: byte %0d not accepted, expected acceptance", i);
        return;
      end
    end
  endtask

  task automatic check_good_writes(input string tag);
    check({tag, "_nwr"}, 32'(wlog_addr.size()), 32'd2);
    if (wlog_addr.size() >= 2) begin
      check({tag, "_a0"}, wlog_addr[0], 32'h0000);
      check({tag, "_d0"}, wlog_data[0], 32'h0000_0013);
      check({tag, "_a1"}, wlog_addr[1], 32'h0004);
      check({tag, "_d1"}, wlog_data[1], 32'h0010_0093);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] w;
    logic [31:0] s;
    int n;
    repeat (2) tick();
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    tick();
    rst = 1'b1;

    // Good image, back-to-back bytes
    build_good(32'h0010_00A6);
    send_bytes(img.size(), 0);
    @(negedge clk);
    check("good_done", 32'(done), 32'd1);
    check("good_cpu_rst", 32'(cpu_rst), 32'd1);
    check_good_writes("good");

    // Handover: CPU port passes straight through
    hold_cpu = 1'b1;
    tick();
    cpu_w_en = 4'h3; cpu_address = 32'h0000_0100;
    cpu_write_data = 32'hDEAD_BEEF; im_read_data = 32'h1234_5678;
    @(negedge clk);
    check("ho_w_en", 32'(im_w_en), 32'h3);
    check("ho_addr", 32'(im_address), 32'h0100);
    check("ho_wdata", im_write_data, 32'hDEAD_BEEF);
    check("ho_rdata", cpu_read_data, 32'h1234_5678);
    hold_cpu = 1'b0;

    // Bad checksum
    do_reset();
    build_good(32'h0010_00A7);
    send_bytes(img.size(), 0);
    @(negedge clk);
    check("bad_error", 32'(error), 32'd1);
    check("bad_cpu_rst", 32'(cpu_rst), 32'd0);
    check("bad_s_ready", 32'(s_ready), 32'd0);
    hold_cpu = 1'b1;
    tick();
    cpu_w_en = 4'hF; cpu_address = 32'h40;
    s_valid = 1'b1; s_data = 8'h5A;
    @(negedge clk);
    check("bad_wen_blocked", 32'(im_w_en), 32'h0);
    repeat (3) tick();
    s_valid = 1'b0;
    hold_cpu = 1'b0;
    check_good_writes("bad");

    // Empty image
    do_reset();
    img.delete(); push_word(32'd0); push_word(32'd0);
    send_bytes(img.size(), 0);
    @(negedge clk);
    check("empty_done", 32'(done), 32'd1);
    check("empty_nwr", 32'(wlog_addr.size()), 32'd0);

    // Oversize word count
    do_reset();
    img.delete(); push_word(32'd16385);
    send_bytes(img.size(), 0);
    @(negedge clk);
    check("over_error", 32'(error), 32'd1);
    check("over_nwr", 32'(wlog_addr.size()), 32'd0);

    // Good image with random gaps
    do_reset();
    build_good(32'h0010_00A6);
    send_bytes(img.size(), 5);
    @(negedge clk);
    check("gap_done", 32'(done), 32'd1);
    check_good_writes("gap");

    // Reset after 5 data bytes, then reload
    do_reset();
    build_good(32'h0010_00A6);
    send_bytes(9, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_s_ready", 32'(s_ready), 32'd0);
    check("mid_w_en", 32'(im_w_en), 32'd0);
    check("mid_addr", 32'(im_address), 32'd0);
    check("mid_wdata", im_write_data, 32'd0);
    check("mid_cpu_rst", 32'(cpu_rst), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_error", 32'(error), 32'd0);
    tick();
    rst = 1'b1;
    wlog_addr.delete();
    wlog_data.delete();
    send_bytes(img.size(), 2);
    @(negedge clk);
    check("reload_done", 32'(done), 32'd1);
    check_good_writes("reload");

    // Random images, some with corrupted checksums
    for (int r = 0; r < 12; r++) begin
      do_reset();
      n = $urandom_range(6, 0);
      img.delete();
      push_word(32'(n));
      s = '0;
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        s += w;
        push_word(w);
      end
      if ($urandom_range(3, 0) == 0) s ^= 32'(1) << $urandom_range(31, 0);
      push_word(s);
      send_bytes(img.size(), $urandom_range(3, 0));
      repeat (4) tick();
      @(negedge clk);
      check("rand_nwr", 32'(wlog_addr.size()), 32'(n));
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
